// File: rtl/evo_pmux_port.sv
// evo_pmux_port: per-port pin multiplexer.
// Each pin is driven by its lowest-index claiming source. Pins claimed by
// more than one source are flagged as conflicts, which are recorded in a sticky
// CONF register and counted in a saturating 16-bit CNT register. Pad inputs
// pass through a 2-flop synchronizer before they are returned to the pmux.
// Optional feature: define EVO_PMUX_PORT_FILTER_EN to add a per-pin stability
// filter of FILT_CYCLES cycles after the synchronizer.
module evo_pmux_port #(
  parameter int PORT_DWIDTH    = 32,
  parameter int MUX_WIDTH      = 16,
  parameter int CSR_AWIDTH     = 8,
  parameter int CSR_DWIDTH     = 32,
  parameter int FILT_CYCLES    = 4,
  parameter int PORT_CONF_ADDR = 0,
  parameter int PORT_CNT_ADDR  = 1
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [PORT_DWIDTH*MUX_WIDTH-1:0] pmux_dir_i,
  input  logic [PORT_DWIDTH*MUX_WIDTH-1:0] pmux_out_i,
  input  logic [PORT_DWIDTH*MUX_WIDTH-1:0] pmux_en_i,
  output logic [PORT_DWIDTH-1:0]           pmux_in_o,
  output logic [PORT_DWIDTH-1:0]           pin_out_o,
  output logic [PORT_DWIDTH-1:0]           pin_oe_o,
  input  logic [PORT_DWIDTH-1:0]           pin_in_i,
  input  logic [CSR_AWIDTH-1:0]            avs_csr_address,
  input  logic                             avs_csr_read,
  input  logic                             avs_csr_write,
  input  logic [CSR_DWIDTH-1:0]            avs_csr_writedata,
  output logic [CSR_DWIDTH-1:0]            avs_csr_readdata,
  output logic                             avs_csr_readdatavalid,
  output logic                             avs_csr_waitrequest,
  output logic                             avs_csr_waitresponse
);

  // CSR handshake: waitrequest is held low, so a read or write is accepted in
  // every cycle it is asserted; read data is returned exactly one cycle later
  // with readdatavalid high for that single cycle (also for unmapped addresses).

  logic [PORT_DWIDTH-1:0] oe_d, out_d, claimed, conflict;
  logic [PORT_DWIDTH-1:0] pin_oe_q, pin_out_q;
  logic [PORT_DWIDTH-1:0] conf_q, conf_d, conf_clr;
  logic [15:0]            cnt_q, cnt_d;
  logic [CSR_DWIDTH-1:0]  rdata_q, rdata_d;
  logic                   rdv_q;
  logic [PORT_DWIDTH-1:0] sync1_q, sync2_q;
  logic                   sel_conf, sel_cnt;

  assign sel_conf = (avs_csr_address == CSR_AWIDTH'(PORT_CONF_ADDR));
  assign sel_cnt  = (avs_csr_address == CSR_AWIDTH'(PORT_CNT_ADDR));

  // Priority select per pin: first claiming source wins, any later claim is a conflict.
  always_comb begin
    oe_d     = '0;
    out_d    = '0;
    claimed  = '0;
    conflict = '0;
    for (int p = 0; p < PORT_DWIDTH; p++) begin
      for (int s = 0; s < MUX_WIDTH; s++) begin
        if (pmux_en_i[PORT_DWIDTH*s+p]) begin
          if (claimed[p]) begin
            conflict[p] = 1'b1;
          end else begin
            claimed[p] = 1'b1;
            oe_d[p]    = pmux_dir_i[PORT_DWIDTH*s+p];
            out_d[p]   = pmux_out_i[PORT_DWIDTH*s+p];
          end
        end
      end
    end
  end

  // CSR next-state: W1C clear on CONF (set wins), clear-on-write CNT (clear wins), read mux.
  always_comb begin
    conf_clr = '0;
    rdata_d  = '0;
    for (int i = 0; i < PORT_DWIDTH; i++) begin
      if (i < CSR_DWIDTH && avs_csr_write && sel_conf) conf_clr[i] = avs_csr_writedata[i];
    end
    conf_d = (conf_q & ~conf_clr) | conflict;
    if (avs_csr_write && sel_cnt) begin
      cnt_d = '0;
    end else if ((|conflict) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
    if (sel_conf) begin
      for (int i = 0; i < CSR_DWIDTH; i++) begin
        if (i < PORT_DWIDTH) rdata_d[i] = conf_q[i];
      end
    end else if (sel_cnt) begin
      for (int i = 0; i < 16; i++) begin
        if (i < CSR_DWIDTH) rdata_d[i] = cnt_q[i];
      end
    end
  end

  // Pad drive, CSR state and read response registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pin_oe_q  <= '0;
      pin_out_q <= '0;
      conf_q    <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      rdv_q     <= 1'b0;
    end else begin
      pin_oe_q  <= oe_d;
      pin_out_q <= out_d;
      conf_q    <= conf_d;
      cnt_q     <= cnt_d;
      rdv_q     <= avs_csr_read;
      if (avs_csr_read) rdata_q <= rdata_d;
    end
  end

  // Two-flop synchronizer for the asynchronous pad inputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pin_in_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef EVO_PMUX_PORT_FILTER_EN
  logic [3:0]             filt_cnt_q [PORT_DWIDTH];
  logic [PORT_DWIDTH-1:0] filt_q;

  // Stability filter: accept a new level only after it has persisted FILT_CYCLES cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      filt_q <= '0;
      for (int p = 0; p < PORT_DWIDTH; p++) filt_cnt_q[p] <= '0;
    end else begin
      for (int p = 0; p < PORT_DWIDTH; p++) begin
        if (sync2_q[p] != filt_q[p]) begin
          if (filt_cnt_q[p] == 4'(FILT_CYCLES - 1)) begin
            filt_q[p]     <= sync2_q[p];
            filt_cnt_q[p] <= '0;
          end else begin
            filt_cnt_q[p] <= filt_cnt_q[p] + 4'd1;
          end
        end else begin
          filt_cnt_q[p] <= '0;
        end
      end
    end
  end

  assign pmux_in_o = filt_q;
`else
  assign pmux_in_o = sync2_q;
`endif

  assign pin_oe_o              = pin_oe_q;
  assign pin_out_o             = pin_out_q;
  assign avs_csr_readdata      = rdata_q;
  assign avs_csr_readdatavalid = rdv_q;
  assign avs_csr_waitrequest   = 1'b0;
  assign avs_csr_waitresponse  = 1'b0;

endmodule

// File: tb/tb_evo_pmux_port.sv
// Self-checking bench for evo_pmux_port: directed scenarios plus randomized
// traffic compared against a behavioural model of the port.
module tb_evo_pmux_port;
  localparam int PW = 32;
  localparam int MW = 16;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int FC = 4;
  localparam int NB = PW * MW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [NB-1:0] dir, pout, en;
  logic [PW-1:0] pmux_in, pin_out, pin_oe, pin_in;
  logic [AW-1:0] addr;
  logic          rd, wr;
  logic [DW-1:0] wdata, rdata;
  logic          rdv, wreq, wresp;

  evo_pmux_port #(
    .PORT_DWIDTH(PW), .MUX_WIDTH(MW), .CSR_AWIDTH(AW), .CSR_DWIDTH(DW),
    .FILT_CYCLES(FC), .PORT_CONF_ADDR(0), .PORT_CNT_ADDR(1)
  ) dut (
    .clk(clk), .rstn(rstn),
    .pmux_dir_i(dir), .pmux_out_i(pout), .pmux_en_i(en),
    .pmux_in_o(pmux_in), .pin_out_o(pin_out), .pin_oe_o(pin_oe), .pin_in_i(pin_in),
    .avs_csr_address(addr), .avs_csr_read(rd), .avs_csr_write(wr),
    .avs_csr_writedata(wdata), .avs_csr_readdata(rdata),
    .avs_csr_readdatavalid(rdv), .avs_csr_waitrequest(wreq),
    .avs_csr_waitresponse(wresp)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  logic [PW-1:0] m_oe, m_out, m_conf, m_in;
  logic [15:0]   m_cnt;
  logic          m_rdv;
  logic [PW-1:0] hist[$];     // pad input value seen at each clock edge
  logic [DW-1:0] exp_q[$];    // expected read data, in issue order

  task automatic model_reset();
    m_oe = '0; m_out = '0; m_conf = '0; m_in = '0; m_cnt = '0; m_rdv = 1'b0;
    hist.delete();
    exp_q.delete();
    for (int i = 0; i < FC + 3; i++) hist.push_back('0);
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    logic [PW-1:0] cf;
    int hits, first;
    logic all_diff;
    if (!rstn) begin
      model_reset();
      return;
    end
    m_rdv = rd;
    if (rd) begin
      if (addr == 8'd0)      exp_q.push_back(DW'(m_conf));
      else if (addr == 8'd1) exp_q.push_back(DW'(m_cnt));
      else                   exp_q.push_back('0);
    end
    cf = '0;
    for (int p = 0; p < PW; p++) begin
      hits = 0;
      first = -1;
      for (int s = 0; s < MW; s++) begin
        if (en[PW*s+p]) begin
          hits++;
          if (first < 0) first = s;
        end
      end
      cf[p]    = (hits >= 2);
      m_oe[p]  = (first >= 0) ? dir[PW*first+p]  : 1'b0;
      m_out[p] = (first >= 0) ? pout[PW*first+p] : 1'b0;
    end
    if (wr && addr == 8'd1)                 m_cnt = '0;
    else if (cf != '0 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    m_conf = (m_conf & ~((wr && addr == 8'd0) ? wdata[PW-1:0] : '0)) | cf;
    hist.push_back(pin_in);
    if (hist.size() > 40) void'(hist.pop_front());
`ifdef EVO_PMUX_PORT_FILTER_EN
    // Synchronized value at this edge is the pad value from two edges back;
    // the output flips once the last FC synchronized values all differ from it.
    for (int p = 0; p < PW; p++) begin
      all_diff = 1'b1;
      for (int j = 0; j < FC; j++) begin
        if (hist[hist.size()-3-j][p] == m_in[p]) all_diff = 1'b0;
      end
      if (all_diff) m_in[p] = ~m_in[p];
    end
`else
    all_diff = 1'b0;
    m_in = hist[hist.size()-2];
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_all();
    logic [DW-1:0] e;
    chk("pin_oe", 64'(pin_oe), 64'(m_oe));
    chk("pin_out", 64'(pin_out), 64'(m_out));
    chk("pmux_in", 64'(pmux_in), 64'(m_in));
    chk("readdatavalid", 64'(rdv), 64'(m_rdv));
    if (m_rdv) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      chk("readdata", 64'(rdata), 64'(e));
    end
    chk("waitrequest", 64'(wreq), 64'(1'b0));
    chk("waitresponse", 64'(wresp), 64'(1'b0));
  endtask

  task automatic csr_read(input logic [AW-1:0] a);
    rd = 1'b1; addr = a;
    tick();
    rd = 1'b0;
    check_all();
  endtask

  task automatic csr_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr = 1'b1; addr = a; wdata = d;
    tick();
    wr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k, r;
    dir = '0; pout = '0; en = '0; pin_in = '0;
    addr = '0; rd = 1'b0; wr = 1'b0; wdata = '0;
    model_reset();
    #12;
    check_all();
    chk("rst_readdata", 64'(rdata), 64'(0));
    @(posedge clk); #1;
    rstn = 1'b1;

    // Lowest-index claim wins; two claims on pin 0 are a conflict.
    en[PW*3+0] = 1'b1; en[PW*7+0] = 1'b1;
    dir[PW*3+0] = 1'b1; pout[PW*3+0] = 1'b1; dir[PW*7+0] = 1'b0;
    tick();
    chk("sel_oe0", 64'(pin_oe[0]), 64'(1));
    chk("sel_out0", 64'(pin_out[0]), 64'(1));
    check_all();
    en = '0;
    csr_read(8'd0);
    chk("conf_after_conflict", 64'(rdata), 64'(32'h1));
    csr_read(8'd1);
    chk("cnt_after_conflict", 64'(rdata), 64'(1));

    // Unclaimed pins drive nothing.
    for (int s = 0; s < MW; s++) begin
      dir[PW*s +: PW] = $urandom; pout[PW*s +: PW] = $urandom;
    end
    en = '0;
    tick();
    chk("unclaimed_oe", 64'(pin_oe), 64'(0));
    chk("unclaimed_out", 64'(pin_out), 64'(0));

    // W1C with a live conflict: the set wins.
    en[PW*0+0] = 1'b1; en[PW*1+0] = 1'b1;
    tick();
    csr_write(8'd0, 32'h1);
    csr_read(8'd0);
    chk("w1c_set_wins", 64'(rdata[0]), 64'(1));
    en = '0;
    tick();
    csr_write(8'd0, 32'h1);
    csr_read(8'd0);
    chk("w1c_cleared", 64'(rdata), 64'(0));

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      en = '0;
      for (int p = 0; p < PW; p++) begin
        k = $urandom_range(0, 3);
        for (int j = 0; j < k; j++) en[PW*$urandom_range(0, MW-1)+p] = 1'b1;
      end
      for (int s = 0; s < MW; s++) begin
        dir[PW*s +: PW] = $urandom; pout[PW*s +: PW] = $urandom;
      end
      pin_in = pin_in ^ ($urandom & $urandom & $urandom);
      rd = 1'b0; wr = 1'b0;
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        rd = 1'b1; addr = (r == 2) ? 8'd3 : AW'(r);
      end else if (r == 3) begin
        wr = 1'b1; addr = 8'd0; wdata = $urandom;
      end else if (r == 4 && $urandom_range(0, 7) == 0) begin
        wr = 1'b1; addr = 8'd1; wdata = $urandom;
      end
      tick();
      check_all();
    end
    rd = 1'b0; wr = 1'b0; en = '0;

    // Input pulse on pin 5.
    pin_in = '0;
    repeat (20) tick();
    check_all();
`ifdef EVO_PMUX_PORT_FILTER_EN
    pin_in[5] = 1'b1;
    repeat (3) tick();
    pin_in[5] = 1'b0;
    repeat (10) begin
      tick();
      chk("short_pulse_blocked", 64'(pmux_in[5]), 64'(0));
    end
    pin_in[5] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("long_pulse", 64'(pmux_in[5]), 64'((i == 6) ? 1 : 0));
    end
    pin_in[5] = 1'b0;
    repeat (8) begin
      tick();
      check_all();
    end
`else
    pin_in[5] = 1'b1;
    tick();
    chk("pulse_cycle1", 64'(pmux_in[5]), 64'(0));
    tick();
    chk("pulse_cycle2", 64'(pmux_in[5]), 64'(1));
    tick();
    pin_in[5] = 1'b0;
    repeat (5) begin
      tick();
      check_all();
    end
`endif

    // CNT saturation and clear-over-increment.
    csr_write(8'd1, 32'h0);
    en[PW*0+0] = 1'b1; en[PW*1+0] = 1'b1;
    repeat (70000) tick();
    csr_read(8'd1);
    chk("cnt_saturated", 64'(rdata), 64'(32'hFFFF));
    csr_write(8'd1, 32'h0);
    csr_read(8'd1);
    chk("cnt_cleared", 64'(rdata), 64'(0));
    en = '0;

    // Reset during a read response.
    en[PW*2+4] = 1'b1; dir[PW*2+4] = 1'b1; pout[PW*2+4] = 1'b1;
    pin_in = 32'hFFFF_FFFF;
    repeat (4) tick();
    rd = 1'b1; addr = 8'd1;
    tick();
    rd = 1'b0;
    rstn = 1'b0;
    #1;
    model_reset();
    chk("rst_rdv", 64'(rdv), 64'(0));
    chk("rst_oe", 64'(pin_oe), 64'(0));
    chk("rst_out", 64'(pin_out), 64'(0));
    chk("rst_in", 64'(pmux_in), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    tick();
    rstn = 1'b1;
    en = '0;
    tick();
    chk("post_rst_rdv", 64'(rdv), 64'(0));
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/evo_pmux_port.md
EVO_PMUX_PORT -- requirements
Module: evo_pmux_port

Interface
REQ-001 SHALL have parameter PORT_DWIDTH, default 32, meaning number of physical pins on the port.
REQ-002 SHALL have parameter MUX_WIDTH, default 16, meaning number of pmux sources per pin.
REQ-003 SHALL have parameter CSR_AWIDTH, default 8, meaning CSR address width.
REQ-004 SHALL have parameter CSR_DWIDTH, default 32, meaning CSR data width.
REQ-005 SHALL have parameter FILT_CYCLES, default 4, meaning input filter stability count (range 2..15).
REQ-006 SHALL have parameters PORT_CONF_ADDR and PORT_CNT_ADDR, default 0 and 1, meaning CSR addresses of the conflict and count registers.
REQ-007 SHALL have port clk, input, 1, meaning the system clock.
REQ-008 SHALL have port rstn, input, 1, meaning the asynchronous, active-low reset.
REQ-009 SHALL have port pmux_dir_i, input, PORT_DWIDTH*MUX_WIDTH, meaning per-source output-enable; slice s occupies bits [PORT_DWIDTH*s +: PORT_DWIDTH].
REQ-010 SHALL have port pmux_out_i, input, PORT_DWIDTH*MUX_WIDTH, meaning per-source output value, sliced the same way.
REQ-011 SHALL have port pmux_en_i, input, PORT_DWIDTH*MUX_WIDTH, meaning per-source claim of a pin, sliced the same way.
REQ-012 SHALL have port pmux_in_o, output, PORT_DWIDTH, meaning conditioned pin input returned to the pmux.
REQ-013 SHALL have port pin_out_o, output, PORT_DWIDTH, meaning pad output value.
REQ-014 SHALL have port pin_oe_o, output, PORT_DWIDTH, meaning pad output enable.
REQ-015 SHALL have port pin_in_i, input, PORT_DWIDTH, meaning asynchronous pad input.
REQ-016 SHALL have the Avalon-MM slave ports avs_csr_address (CSR_AWIDTH), avs_csr_read, avs_csr_write, avs_csr_writedata (CSR_DWIDTH) as inputs, and avs_csr_readdata (CSR_DWIDTH), avs_csr_readdatavalid, avs_csr_waitrequest, avs_csr_waitresponse as outputs.

Function
REQ-017 SHALL select, per pin p, the lowest-index source s with pmux_en_i[PORT_DWIDTH*s+p]=1.
REQ-018 SHALL register pin_oe_o[p] equal to that source's dir bit and pin_out_o[p] equal to its out bit, with exactly 1 cycle of latency.
REQ-019 SHALL drive pin_oe_o[p]=0 and pin_out_o[p]=0, registered, when no source claims pin p.
REQ-020 SHALL flag a conflict on pin p in any cycle in which two or more en bits for p are set; the selection still follows REQ-017.
REQ-021 SHALL set the sticky CONF[p] bit one cycle after the conflict is flagged.
REQ-022 SHALL clear CONF bits by CSR write-1; if set and clear coincide on the same bit, set wins.
REQ-023 SHALL increment the 16-bit CNT register once per cycle in which any pin is in conflict, saturating at 0xFFFF.
REQ-024 SHALL clear CNT to 0 on any CSR write to PORT_CNT_ADDR; the clear wins over a same-cycle increment.
REQ-025 SHALL pass pin_in_i through a 2-flop synchronizer per pin.
REQ-026 SHALL return reads with avs_csr_readdatavalid one cycle after avs_csr_read; readdata SHALL be CONF zero-extended or CNT zero-extended, and 0 for unmapped addresses, with readdatavalid still asserted.
REQ-027 SHALL tie avs_csr_waitrequest and avs_csr_waitresponse to 0.

Reset
REQ-028 SHALL, while rstn=0, asynchronously force pin_oe_o, pin_out_o, pmux_in_o, the synchronizers, the filter state, CONF, CNT, avs_csr_readdata and avs_csr_readdatavalid to 0.
REQ-029 SHALL, when reset is asserted mid-operation, discard any in-flight read; no readdatavalid SHALL follow the release of reset.

Configuration
REQ-030 SHALL, with macro EVO_PMUX_PORT_FILTER_EN defined, update pmux_in_o[p] to the synchronized value only after that value has differed from pmux_in_o[p] for FILT_CYCLES consecutive cycles.
REQ-031 SHALL restart the per-pin filter counter when the synchronized value reverts before the count is reached, so a glitch shorter than FILT_CYCLES never reaches pmux_in_o.
REQ-032 SHALL, without EVO_PMUX_PORT_FILTER_EN, drive pmux_in_o directly from the synchronizer output (2-cycle latency) and instantiate no filter logic.

Verification
REQ-033 SHALL cover pin-drive selection: en slices 3 and 7 set on pin 0 with dir3=1, out3=1, dir7=0 -> next cycle pin_oe_o[0]=1, pin_out_o[0]=1; CONF reads 0x00000001; CNT reads 1 after one cycle.
REQ-034 SHALL cover the unclaimed-pin case: no en bits set -> pin_oe_o=0 and pin_out_o=0 on all pins one cycle later.
REQ-035 SHALL cover W1C precedence: write 0x1 to CONF while pin 0 is still in conflict -> CONF[0] stays 1; remove the conflict and write 0x1 again -> CONF reads 0.
REQ-036 SHALL cover CNT saturation and clear: hold a conflict for 70000 cycles -> CNT=0xFFFF; write CNT -> next read returns 0 even though the conflict persists in the write cycle.
REQ-037 SHALL cover the input filter: with FILTER_EN and FILT_CYCLES=4, a 3-cycle pulse on pin_in_i[5] -> pmux_in_o[5] stays 0; a 6-cycle pulse -> pmux_in_o[5]=1 six cycles after the rising edge (2 sync cycles plus 4 filter cycles). Without the macro, the 3-cycle pulse appears after 2 cycles.
REQ-038 SHALL cover reset mid-read: assert rstn=0 in the cycle after avs_csr_read -> readdatavalid=0, and all outputs are 0 immediately.
